// File: rtl/fft_frame_sequencer.sv
// Per-frame FFT sequencer: starts the FFT on each vsync rising edge, waits for done
// (with timeout), then walks the bins applying peak-hold and decay to the bar buffer.

module fft_bin_lane #(
   parameter int MAG_W       = 14,
   parameter int HOLD_FRAMES = 8,
   parameter int DECAY_SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [MAG_W-1:0] mag,
   output logic [MAG_W-1:0] bar
);
   logic [7:0]       hold;
   logic [MAG_W-1:0] dec;

   // Small non-zero bars still fall by at least one step so they reach zero.
   always_comb begin
      dec = bar >> DECAY_SHIFT;
      if (dec == '0 && bar != '0) dec = MAG_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bar  <= '0;
         hold <= '0;
      end else if (en) begin
         if (mag >= bar) begin
            bar  <= mag;
            hold <= 8'(HOLD_FRAMES);
         end else if (hold != '0) begin
            hold <= hold - 8'd1;
         end else begin
            bar <= bar - dec;
         end
      end
   end
endmodule

module fft_frame_sequencer #(
   parameter int N           = 16,
   parameter int MAG_W       = 14,
   parameter int HOLD_FRAMES = 8,
   parameter int DECAY_SHIFT = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   output logic               fft_start,
   input  logic               fft_done,
   input  logic [N*MAG_W-1:0] mag_in,
   output logic [N*MAG_W-1:0] bars,
   output logic               bars_valid,
   output logic               busy,
   output logic [7:0]         timeout_count,
   output logic [7:0]         overrun_count
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int IDX_W = $clog2(N);

   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, UPDATE, DONE} state_t;

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic                      tick_q, done_q;
   logic                      tick_rise, done_rise;
   logic [N-1:0][MAG_W-1:0]   bar_q;

   assign tick_rise = frame_tick & ~tick_q;
   assign done_rise = fft_done & ~done_q;
   assign bars      = bar_q;

   // One lane per bin; only the lane addressed by idx updates during the walk.
   for (genvar i = 0; i < N; i++) begin : g_lane
      fft_bin_lane #(
         .MAG_W(MAG_W), .HOLD_FRAMES(HOLD_FRAMES), .DECAY_SHIFT(DECAY_SHIFT)
      ) u_lane (
         .clk(clk),
         .rst(rst),
         .en (state == UPDATE && idx == IDX_W'(i)),
         .mag(mag_in[i*MAG_W +: MAG_W]),
         .bar(bar_q[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         tick_q        <= 1'b0;
         done_q        <= 1'b0;
         fft_start     <= 1'b0;
         bars_valid    <= 1'b0;
         busy          <= 1'b0;
         timeout_count <= '0;
         overrun_count <= '0;
      end else begin
         tick_q     <= frame_tick;
         done_q     <= fft_done;
         fft_start  <= 1'b0;
         bars_valid <= 1'b0;
         // A tick while a frame is in flight is dropped, not queued.
         if (tick_rise && state != IDLE && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
         case (state)
            IDLE: if (tick_rise) begin
               state     <= START;
               fft_start <= 1'b1;
               busy      <= 1'b1;
            end
            START: begin
               cnt   <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  state <= UPDATE;
                  idx   <= '0;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UPDATE: begin
               if (idx == IDX_W'(N-1)) begin
                  state      <= DONE;
                  bars_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: table of frames checked through a bars_valid
// scoreboard, plus hand-written timing, overrun, timeout and reset sequences.

module tb_fft_frame_sequencer;
   localparam int N = 16, MAG_W = 14, TO = 31, W = N*MAG_W;

   logic         clk = 1'b0, rst = 1'b0, frame_tick = 1'b0, fft_done = 1'b0;
   logic [W-1:0] mag_in = '0;
   logic         fft_start, bars_valid, busy;
   logic [W-1:0] bars;
   logic [7:0]   timeout_count, overrun_count;

   int compared = 0, mismatched = 0, starts = 0, valids = 0;
   logic [W-1:0] sb[$];

   typedef struct { logic [W-1:0] mag; logic [W-1:0] exp; } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   fft_frame_sequencer #(
      .N(N), .MAG_W(MAG_W), .HOLD_FRAMES(8), .DECAY_SHIFT(4), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .fft_start(fft_start),
      .fft_done(fft_done), .mag_in(mag_in), .bars(bars), .bars_valid(bars_valid),
      .busy(busy), .timeout_count(timeout_count), .overrun_count(overrun_count)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input int b0, b1, b2, b3, rest);
      logic [W-1:0] v;
      for (int i = 0; i < N; i++)
         v[i*MAG_W +: MAG_W] = MAG_W'(i == 0 ? b0 : i == 1 ? b1 : i == 2 ? b2 : i == 3 ? b3 : rest);
      return v;
   endfunction

   // Scoreboard: every bars_valid pops one expected frame.
   always @(negedge clk) begin
      if (fft_start) starts++;
      if (bars_valid) begin
         valids++;
         if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected bars_valid: got 1 expected 0");
         end else chk("frame bars", bars, sb.pop_front());
      end
   end

   task automatic run_frame(input logic [W-1:0] mag, input logic [W-1:0] exp, input int dly);
      int v0, s0, n;
      @(negedge clk); frame_tick = 1'b0; fft_done = 1'b0; mag_in = mag;
      repeat (2) @(negedge clk);
      sb.push_back(exp); v0 = valids; s0 = starts;
      frame_tick = 1'b1;
      repeat (dly + 2) @(negedge clk);
      fft_done = 1'b1;
      n = 0;
      while (valids == v0 && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) chk("bars_valid wait", 0, 1);
      @(negedge clk);
      chk("start pulses", W'(starts - s0), 1);
   endtask

   task automatic timeout_frame(input logic done_lvl, output int wc);
      int n;
      @(negedge clk); frame_tick = 1'b0; fft_done = done_lvl;
      repeat (2) @(negedge clk);
      frame_tick = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!fft_start && n < 5);
      n = 0;
      while (busy && n < TO + 10) begin @(negedge clk); n++; end
      wc = n - 1;
   endtask

   initial begin
      logic [W-1:0] part;
      int s0, v0, n, wc;

      tbl[0].mag = pk(1600, 10, 1, 0, 1000);  tbl[0].exp = pk(1600, 10, 1, 0, 1000);
      for (int i = 1; i <= 8; i++) begin
         tbl[i].mag = '0;                     tbl[i].exp = pk(1600, 10, 1, 0, 1000);
      end
      tbl[9].mag  = '0;                       tbl[9].exp  = pk(1500, 9, 0, 0, 938);
      tbl[10].mag = '0;                       tbl[10].exp = pk(1407, 8, 0, 0, 880);
      tbl[11].mag = pk(2000, 0, 0, 0, 0);     tbl[11].exp = pk(2000, 7, 0, 0, 825);

      #1;
      chk("reset bars", bars, '0);
      chk("reset outputs", W'({fft_start, bars_valid, busy, timeout_count, overrun_count}), '0);
      @(negedge clk); rst = 1'b1;

      // First frame with exact cycle timing
      mag_in = pk(100, 100, 100, 100, 100);
      sb.push_back(mag_in);
      @(negedge clk); frame_tick = 1'b1; s0 = starts;
      @(negedge clk);
      chk("fft_start at T+1", W'(fft_start), 1);
      chk("busy in START", W'(busy), 1);
      repeat (20) @(negedge clk);
      fft_done = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         part = '0;
         for (int j = 0; j < k; j++) part[j*MAG_W +: MAG_W] = MAG_W'(100);
         chk($sformatf("walk bins<%0d", k), bars, part);
         chk("no early bars_valid", W'(bars_valid), 0);
      end
      @(negedge clk);
      chk("bars_valid at D+17", W'(bars_valid), 1);
      chk("all bars 100", bars, pk(100, 100, 100, 100, 100));
      @(negedge clk);
      chk("bars_valid one cycle", W'(bars_valid), 0);
      chk("busy falls", W'(busy), 0);
      chk("single fft_start", W'(starts - s0), 1);

      // Clean slate for the hold/decay table
      frame_tick = 1'b0; fft_done = 1'b0; rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 12; i++) run_frame(tbl[i].mag, tbl[i].exp, 3 + i);

      // Overrun: second tick while waiting for done
      @(negedge clk); frame_tick = 1'b0; fft_done = 1'b0; mag_in = pk(3000, 3000, 3000, 3000, 3000);
      repeat (2) @(negedge clk);
      sb.push_back(mag_in); s0 = starts; v0 = valids;
      frame_tick = 1'b1;
      repeat (3) @(negedge clk); frame_tick = 1'b0;
      @(negedge clk); frame_tick = 1'b1;
      repeat (2) @(negedge clk);
      chk("overrun_count", W'(overrun_count), 1);
      repeat (5) @(negedge clk); fft_done = 1'b1;
      n = 0;
      while (valids == v0 && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) chk("overrun frame completes", 0, 1);
      repeat (2) @(negedge clk);
      chk("overrun single start", W'(starts - s0), 1);
      chk("overrun busy done", W'(busy), 0);

      // Timeouts
      v0 = valids;
      timeout_frame(1'b0, wc);
      chk("timeout wait cycles", W'(wc), TO + 1);
      chk("timeout_count 1", W'(timeout_count), 1);
      chk("bars kept on timeout", bars, pk(3000, 3000, 3000, 3000, 3000));
      timeout_frame(1'b1, wc);
      chk("done high at start times out", W'(timeout_count), 2);
      for (int i = 0; i < 298; i++) timeout_frame(1'b0, wc);
      chk("timeout_count saturates", W'(timeout_count), 255);
      chk("no bars_valid on timeout", W'(valids - v0), 0);
      chk("overrun unchanged", W'(overrun_count), 1);

      // Async reset in the middle of the walk
      @(negedge clk); frame_tick = 1'b0; fft_done = 1'b0; mag_in = pk(500, 500, 500, 500, 500);
      repeat (2) @(negedge clk);
      frame_tick = 1'b1;
      repeat (3) @(negedge clk); fft_done = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid-walk reset bars", bars, '0);
      chk("mid-walk reset outputs", W'({fft_start, bars_valid, busy, timeout_count, overrun_count}), '0);
      frame_tick = 1'b0; fft_done = 1'b0;
      @(negedge clk); rst = 1'b1; s0 = starts;
      repeat (10) @(negedge clk);
      chk("idle after release", W'(starts - s0), 0);
      chk("not busy after release", W'(busy), 0);
      run_frame(pk(42, 42, 42, 42, 42), pk(42, 42, 42, 42, 42), 4);
      chk("scoreboard drained", W'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
